multicycle_ctrl: RTL and testbench

- Parametrised multicycle RV32I control unit; next generation of the core's lw/sw-only controller FSM.
- Adds byte/half/unsigned loads and stores, branches, JAL, LUI and AUIPC.
- Adds a mem_req/mem_ready handshake with a wait-state timeout and a sticky fault state.
- Sits between the instruction register/flags and the datapath muxes, ALU, register file and memory port.

---
 rtl/multicycle_ctrl_if.sv | 46 ++++
 rtl/multicycle_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
// multicycle_ctrl_if : control-unit <-> datapath/memory signal bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface multicycle_ctrl_if #(
  parameter int ALU_CTRL_W = 4
);
  logic [6:0]            op;
  logic [2:0]            funct3;
  logic                  funct7_5;
  logic                  zero;
  logic                  mem_ready;
  logic                  mem_req;
  logic                  mem_write;
  logic                  adr_src;
  logic                  pc_write;
  logic                  ir_write;
  logic                  reg_write;
  logic [1:0]            result_src;
  logic [1:0]            alu_src_a;
  logic [1:0]            alu_src_b;
  logic [2:0]            imm_src;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic [1:0]            mem_size;
  logic                  load_unsigned;
  logic                  mem_fault;
  logic [3:0]            state_o;

  modport master (
    input  op, funct3, funct7_5, zero, mem_ready,
    output mem_req, mem_write, adr_src, pc_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_control,
           mem_size, load_unsigned, mem_fault, state_o
  );

  modport slave (
    output op, funct3, funct7_5, zero, mem_ready,
    input  mem_req, mem_write, adr_src, pc_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_control,
           mem_size, load_unsigned, mem_fault, state_o
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl : multicycle RV32I control FSM with memory handshake timeout
// Optional macro TRAP_ILLEGAL_EN: illegal opcodes / memory funct3 go to FAULT.
// Rev 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
  parameter int ALU_CTRL_W  = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  wire logic         clk,
  input  wire logic         reset,
  multicycle_ctrl_if.master bus
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(MEM_TIMEOUT);

  localparam logic [6:0] C_OP_LOAD  = 7'd3;
  localparam logic [6:0] C_OP_STORE = 7'd35;
  localparam logic [6:0] C_OP_R     = 7'd51;
  localparam logic [6:0] C_OP_I     = 7'd19;
  localparam logic [6:0] C_OP_BR    = 7'd99;
  localparam logic [6:0] C_OP_JAL   = 7'd111;
  localparam logic [6:0] C_OP_LUI   = 7'd55;
  localparam logic [6:0] C_OP_AUIPC = 7'd23;

  localparam logic [ALU_CTRL_W-1:0] C_ADD   = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] C_SUB   = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] C_AND   = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] C_OR    = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] C_XOR   = ALU_CTRL_W'(4);
  localparam logic [ALU_CTRL_W-1:0] C_SLT   = ALU_CTRL_W'(5);
  localparam logic [ALU_CTRL_W-1:0] C_SLTU  = ALU_CTRL_W'(6);
  localparam logic [ALU_CTRL_W-1:0] C_SLL   = ALU_CTRL_W'(7);
  localparam logic [ALU_CTRL_W-1:0] C_SRL   = ALU_CTRL_W'(8);
  localparam logic [ALU_CTRL_W-1:0] C_SRA   = ALU_CTRL_W'(9);
  localparam logic [ALU_CTRL_W-1:0] C_PASSB = ALU_CTRL_W'(10);

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_UTYPE    = 4'd9,
    S_JAL      = 4'd10,
    S_ALUWB    = 4'd11,
    S_BRANCH   = 4'd12,
    S_FAULT    = 4'd13
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             timeout_hit;
  logic             in_wait_state;

  logic                  mem_req, mem_write, adr_src, pc_write, ir_write, reg_write;
  logic [1:0]            result_src, alu_src_a, alu_src_b, mem_size;
  logic [2:0]            imm_src;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic                  load_unsigned, mem_fault;

  // Register-register and immediate arithmetic share one decoder; only R-type may SUB.
  function automatic logic [ALU_CTRL_W-1:0] alu_dec(input logic [2:0] f3,
                                                    input logic f7, input logic is_r);
    case (f3)
      3'b000:  alu_dec = (is_r && f7) ? C_SUB : C_ADD;
      3'b001:  alu_dec = C_SLL;
      3'b010:  alu_dec = C_SLT;
      3'b011:  alu_dec = C_SLTU;
      3'b100:  alu_dec = C_XOR;
      3'b101:  alu_dec = f7 ? C_SRA : C_SRL;
      3'b110:  alu_dec = C_OR;
      default: alu_dec = C_AND;
    endcase
  endfunction

  assign in_wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                         (state_q == S_MEMWRITE);
  assign timeout_hit   = (MEM_TIMEOUT > 0) && (wait_q == C_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Any state change clears the counter, so each wait state starts counting from zero.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)
      wait_d = '0;
    else if (in_wait_state && !bus.mem_ready)
      wait_d = wait_q + 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    imm_src       = 3'b000;
    alu_control   = C_ADD;
    mem_size      = 2'b00;
    load_unsigned = 1'b0;
    mem_fault     = 1'b0;
    unique case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = bus.mem_ready;
        pc_write   = bus.mem_ready;
        if (bus.mem_ready)  state_d = S_DECODE;
        else if (timeout_hit) state_d = S_FAULT;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (bus.op == C_OP_JAL) ? 3'b011 : 3'b010;
        case (bus.op)
          C_OP_LOAD, C_OP_STORE: state_d = S_MEMADR;
          C_OP_R:                state_d = S_EXECR;
          C_OP_I:                state_d = S_EXECI;
          C_OP_BR:               state_d = S_BRANCH;
          C_OP_JAL:              state_d = S_JAL;
          C_OP_LUI, C_OP_AUIPC:  state_d = S_UTYPE;
`ifdef TRAP_ILLEGAL_EN
          default:               state_d = S_FAULT;
`else
          default:               state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (bus.op == C_OP_LOAD) ? 3'b000 : 3'b001;
        state_d   = (bus.op == C_OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
`ifdef TRAP_ILLEGAL_EN
        if ((bus.op == C_OP_LOAD && (bus.funct3 == 3'b011 || bus.funct3[2:1] == 2'b11)) ||
            (bus.op != C_OP_LOAD && bus.funct3 > 3'b010))
          state_d = S_FAULT;
`endif
      end
      S_MEMREAD: begin
        mem_req       = 1'b1;
        adr_src       = 1'b1;
        mem_size      = bus.funct3[1:0];
        load_unsigned = bus.funct3[2];
        if (bus.mem_ready)    state_d = S_MEMWB;
        else if (timeout_hit) state_d = S_FAULT;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        mem_size  = bus.funct3[1:0];
        if (bus.mem_ready)    state_d = S_FETCH;
        else if (timeout_hit) state_d = S_FAULT;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_dec(bus.funct3, bus.funct7_5, 1'b1);
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_dec(bus.funct3, bus.funct7_5, 1'b0);
        state_d     = S_ALUWB;
      end
      S_UTYPE: begin
        alu_src_b = 2'b01;
        imm_src   = 3'b100;
        if (bus.op == C_OP_LUI) alu_control = C_PASSB;
        else                    alu_src_a   = 2'b01;
        state_d = S_ALUWB;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        case (bus.funct3[2:1])
          2'b00:   alu_control = C_SUB;
          2'b10:   alu_control = C_SLT;
          default: alu_control = C_SLTU;
        endcase
        // SLT/SLTU leave zero set when the "less than" test fails.
        pc_write = (bus.funct3 == 3'b000 || bus.funct3[2:0] == 3'b101 ||
                    bus.funct3 == 3'b111) ? bus.zero : ~bus.zero;
        state_d  = S_FETCH;
      end
      S_FAULT: mem_fault = 1'b1;
      default: state_d = S_FAULT;
    endcase
  end

  assign bus.mem_req       = mem_req;
  assign bus.mem_write     = mem_write;
  assign bus.adr_src       = adr_src;
  assign bus.pc_write      = pc_write;
  assign bus.ir_write      = ir_write;
  assign bus.reg_write     = reg_write;
  assign bus.result_src    = result_src;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.imm_src       = imm_src;
  assign bus.alu_control   = alu_control;
  assign bus.mem_size      = mem_size;
  assign bus.load_unsigned = load_unsigned;
  assign bus.mem_fault     = mem_fault;
  assign bus.state_o       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// tb_multicycle_ctrl : scoreboard bench for multicycle_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  localparam logic [6:0] OP_LOAD = 7'd3,  OP_STORE = 7'd35, OP_R   = 7'd51, OP_I = 7'd19;
  localparam logic [6:0] OP_BR   = 7'd99, OP_JAL   = 7'd111, OP_LUI = 7'd55;
  localparam logic [6:0] OP_AUIPC = 7'd23, OP_BAD  = 7'h7F;

  logic clk = 1'b1;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [26:0] exp_q[$];
  string       tag_q[$];

  multicycle_ctrl_if #(.ALU_CTRL_W(4)) bus ();

  multicycle_ctrl #(.ALU_CTRL_W(4), .MEM_TIMEOUT(15)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  wire logic [26:0] obs = {bus.state_o, bus.mem_req, bus.mem_write, bus.adr_src,
                           bus.pc_write, bus.ir_write, bus.reg_write, bus.result_src,
                           bus.alu_src_a, bus.alu_src_b, bus.imm_src, bus.alu_control,
                           bus.mem_size, bus.load_unsigned, bus.mem_fault};

  function automatic logic [26:0] E(input logic [3:0] st, input logic mreq, mwr, adr,
                                    pcw, irw, rw, input logic [1:0] rs, sa, sb,
                                    input logic [2:0] imm, input logic [3:0] alu,
                                    input logic [1:0] msz, input logic lu, flt);
    return {st, mreq, mwr, adr, pcw, irw, rw, rs, sa, sb, imm, alu, msz, lu, flt};
  endfunction

  function automatic logic [26:0] fetch_e(input logic r);
    return E(4'd1, 1'b1, 1'b0, 1'b0, r, r, 1'b0, 2'b10, 2'b00, 2'b10, 3'd0, 4'd0, 2'd0, 1'b0, 1'b0);
  endfunction

  function automatic logic [26:0] dec_e(input logic [2:0] imm);
    return E(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 4'd0, 2'd0, 1'b0, 1'b0);
  endfunction

  function automatic logic [26:0] branch_e(input logic pcw);
    return E(4'd12, 1'b0, 1'b0, 1'b0, pcw, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'd0, 4'd1, 2'd0, 1'b0, 1'b0);
  endfunction

  localparam logic [26:0] E_RST   = 27'd0;
  localparam logic [26:0] E_FAULT = {4'd13, 23'd1};
  localparam logic [26:0] E_ALUWB = {4'd11, 5'b00000, 1'b1, 17'd0};
  localparam logic [26:0] E_MEMWB = {4'd5, 5'b00000, 1'b1, 2'b01, 15'd0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Inputs change on the falling edge; expectation describes the cycle just started.
  task automatic step(input logic rst, input logic [6:0] op_v, input logic [2:0] f3,
                      input logic f75, input logic z, input logic rdy,
                      input logic [26:0] e, input string tag);
    @(negedge clk);
    reset = rst; bus.op = op_v; bus.funct3 = f3; bus.funct7_5 = f75;
    bus.zero = z; bus.mem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, OP_R, 3'd0, 1'b0, 1'b0, 1'b1, E_RST, "reset_state");
  endtask

  always @(negedge clk) begin
    #2;
    if (exp_q.size() > 0) chk(tag_q.pop_front(), 32'(obs), 32'(exp_q.pop_front()));
  end

  initial begin
    reset = 1'b1;
    bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7_5 = 1'b0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    do_reset();

    // add
    step(0, OP_R, 3'd0, 0, 0, 1, fetch_e(1), "add_fetch");
    step(0, OP_R, 3'd0, 0, 0, 1, dec_e(3'd2), "add_decode");
    step(0, OP_R, 3'd0, 0, 0, 1, E(4'd7, 0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'd0, 4'd0, 2'd0, 0, 0), "add_exec");
    step(0, OP_R, 3'd0, 0, 0, 1, E_ALUWB, "add_aluwb");
    step(0, OP_R, 3'd0, 0, 0, 1, fetch_e(1), "add_refetch");

    // lhu with three wait states
    step(0, OP_LOAD, 3'd5, 0, 0, 0, dec_e(3'd2), "lhu_decode");
    step(0, OP_LOAD, 3'd5, 0, 0, 0, E(4'd3, 0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'd0, 4'd0, 2'd0, 0, 0), "lhu_memadr");
    for (int i = 0; i < 4; i++)
      step(0, OP_LOAD, 3'd5, 0, 0, (i == 3), E(4'd4, 1,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'd0, 4'd0, 2'd1, 1, 0), "lhu_memread");
    step(0, OP_LOAD, 3'd5, 0, 0, 1, E_MEMWB, "lhu_memwb");
    step(0, OP_LOAD, 3'd5, 0, 0, 1, fetch_e(1), "lhu_fetch");

    // bne taken then not taken
    step(0, OP_BR, 3'd1, 0, 0, 1, dec_e(3'd2), "bne_decode");
    step(0, OP_BR, 3'd1, 0, 0, 1, branch_e(1), "bne_taken");
    step(0, OP_BR, 3'd1, 0, 1, 1, fetch_e(1), "bne_fetch");
    step(0, OP_BR, 3'd1, 0, 1, 1, dec_e(3'd2), "bne_decode2");
    step(0, OP_BR, 3'd1, 0, 1, 1, branch_e(0), "bne_not_taken");
    step(0, OP_BR, 3'd1, 0, 1, 1, fetch_e(1), "bne_fetch2");

    // jal
    step(0, OP_JAL, 3'd0, 0, 0, 1, dec_e(3'd3), "jal_decode");
    step(0, OP_JAL, 3'd0, 0, 0, 1, E(4'd10, 0,0,0,1,0,0, 2'b00, 2'b01, 2'b10, 3'd0, 4'd0, 2'd0, 0, 0), "jal_exec");
    step(0, OP_JAL, 3'd0, 0, 0, 1, E_ALUWB, "jal_aluwb");
    step(0, OP_JAL, 3'd0, 0, 0, 1, fetch_e(1), "jal_fetch");

    // lui and auipc
    step(0, OP_LUI, 3'd0, 0, 0, 1, dec_e(3'd2), "lui_decode");
    step(0, OP_LUI, 3'd0, 0, 0, 1, E(4'd9, 0,0,0,0,0,0, 2'b00, 2'b00, 2'b01, 3'd4, 4'd10, 2'd0, 0, 0), "lui_utype");
    step(0, OP_LUI, 3'd0, 0, 0, 1, E_ALUWB, "lui_aluwb");
    step(0, OP_AUIPC, 3'd0, 0, 0, 1, fetch_e(1), "auipc_fetch");
    step(0, OP_AUIPC, 3'd0, 0, 0, 1, dec_e(3'd2), "auipc_decode");
    step(0, OP_AUIPC, 3'd0, 0, 0, 1, E(4'd9, 0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'd4, 4'd0, 2'd0, 0, 0), "auipc_utype");
    step(0, OP_AUIPC, 3'd0, 0, 0, 1, E_ALUWB, "auipc_aluwb");

    // srai, then sub
    step(0, OP_I, 3'd5, 1, 0, 1, fetch_e(1), "srai_fetch");
    step(0, OP_I, 3'd5, 1, 0, 1, dec_e(3'd2), "srai_decode");
    step(0, OP_I, 3'd5, 1, 0, 1, E(4'd8, 0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'd0, 4'd9, 2'd0, 0, 0), "srai_exec");
    step(0, OP_I, 3'd5, 1, 0, 1, E_ALUWB, "srai_aluwb");
    step(0, OP_R, 3'd0, 1, 0, 1, fetch_e(1), "sub_fetch");
    step(0, OP_R, 3'd0, 1, 0, 1, dec_e(3'd2), "sub_decode");
    step(0, OP_R, 3'd0, 1, 0, 1, E(4'd7, 0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'd0, 4'd1, 2'd0, 0, 0), "sub_exec");
    step(0, OP_R, 3'd0, 1, 0, 1, E_ALUWB, "sub_aluwb");

    // unknown opcode
    step(0, OP_BAD, 3'd0, 0, 0, 1, fetch_e(1), "bad_fetch");
    step(0, OP_BAD, 3'd0, 0, 0, 1, dec_e(3'd2), "bad_decode");
`ifdef TRAP_ILLEGAL_EN
    step(0, OP_BAD, 3'd0, 0, 0, 1, E_FAULT, "bad_fault");
    step(0, OP_BAD, 3'd0, 0, 0, 1, E_FAULT, "bad_fault_sticky");
`else
    step(0, OP_BAD, 3'd0, 0, 0, 1, fetch_e(1), "bad_nop_fetch");
`endif
    do_reset();

    // fetch timeout: 16 waiting cycles, then sticky fault
    for (int i = 0; i < 16; i++)
      step(0, OP_R, 3'd0, 0, 0, 0, fetch_e(0), "to_wait");
    step(0, OP_R, 3'd0, 0, 0, 1, E_FAULT, "to_fault");
    step(0, OP_R, 3'd0, 0, 0, 1, E_FAULT, "to_fault_sticky");
    do_reset();

    // ready on the limit cycle wins
    for (int i = 0; i < 15; i++)
      step(0, OP_R, 3'd0, 0, 0, 0, fetch_e(0), "edge_wait");
    step(0, OP_R, 3'd0, 0, 0, 1, fetch_e(1), "edge_ready");
    step(0, OP_R, 3'd0, 0, 0, 1, dec_e(3'd2), "edge_decode");
    do_reset();

    // reset during a store wait aborts the access
    step(0, OP_STORE, 3'd2, 0, 0, 1, fetch_e(1), "sw_fetch");
    step(0, OP_STORE, 3'd2, 0, 0, 0, dec_e(3'd2), "sw_decode");
    step(0, OP_STORE, 3'd2, 0, 0, 0, E(4'd3, 0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'd1, 4'd0, 2'd0, 0, 0), "sw_memadr");
    step(0, OP_STORE, 3'd2, 0, 0, 0, E(4'd6, 1,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'd0, 4'd0, 2'd2, 0, 0), "sw_wait");
    step(1, OP_STORE, 3'd2, 0, 0, 0, E(4'd6, 1,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'd0, 4'd0, 2'd2, 0, 0), "sw_wait_rst");
    step(0, OP_STORE, 3'd2, 0, 0, 0, E_RST, "sw_aborted");

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #4;
    if (exp_q.size() > 0) chk("drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
